// File: rtl/wb_backward_router.sv
// wb_backward_router
// Write-response (B channel) return-path router for the interconnect.
// A packed {BID,BRESP,BUSER} word enters through a two-entry skid buffer.
// Each beat is steered to one master port, chosen by the top BID bits.
// Beats whose select value has no master port are discarded and counted.
// Delivered error responses (BRESP[1]=1) are also counted.
// Both counters saturate.

module wb_backward_router #(
  parameter  int ID_WIDTH    = 8,
  parameter  int USER_WIDTH  = 4,
  parameter  int NUM_MASTERS = 4,
  parameter  int CNT_WIDTH   = 16,
  localparam int SEL_WIDTH   = $clog2(NUM_MASTERS),
  localparam int DATA_W      = ID_WIDTH + 2 + USER_WIDTH
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [DATA_W-1:0]      DATA,
  input  logic                   VALID,
  output logic                   READY,
  output logic [ID_WIDTH-1:0]    BID,
  output logic [1:0]             BRESP,
  output logic [USER_WIDTH-1:0]  BUSER,
  output logic [NUM_MASTERS-1:0] BVALID,
  input  logic [NUM_MASTERS-1:0] BREADY,
  output logic [CNT_WIDTH-1:0]   ERR_CNT,
  output logic [CNT_WIDTH-1:0]   DROP_CNT
);

  // One extra bit lets the drop compare hold the value NUM_MASTERS itself.
  localparam logic [SEL_WIDTH:0] MASTER_LIMIT = (SEL_WIDTH + 1)'(NUM_MASTERS);

  logic                  outValid;
  logic [DATA_W-1:0]     outData;
  logic                  skidValid;
  logic [DATA_W-1:0]     skidData;

  logic [SEL_WIDTH-1:0]  sel;
  logic                  drop;
  logic                  breadySel;
  logic                  accept;
  logic                  consume;
  logic                  outFree;
  logic                  loadOutFromSkid;
  logic                  loadOutFromData;
  logic                  loadSkid;
  logic                  errHit;
  logic                  dropHit;
  logic [CNT_WIDTH-1:0]  errCnt;
  logic [CNT_WIDTH-1:0]  dropCnt;

  // The master is picked by the top BID bits of the beat in the output register.
  assign sel  = outData[DATA_W-1 -: SEL_WIDTH];
  assign drop = {1'b0, sel} >= MASTER_LIMIT;

  // The input side stays ready while the skid slot is empty.
  // It is held off during reset so that no beat is captured while reset is active.
  assign READY  = ~skidValid & ~RESET;
  assign accept = VALID & READY;

  // Select the ready of the addressed master. An out-of-range select sees 0 here.
  // The drop term in consume covers that case.
  always_comb begin
    breadySel = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (sel == SEL_WIDTH'(i)) begin
        breadySel = BREADY[i];
      end
    end
  end

  // A dropped beat always leaves the output register after one cycle.
  // A routable beat leaves on the selected master's handshake.
  assign consume = outValid & (drop | breadySel);
  assign outFree = ~outValid | consume;

  // The skid entry is older than any new beat, so it refills the output register first.
  assign loadOutFromSkid = outFree & skidValid;
  assign loadOutFromData = outFree & ~skidValid & accept;
  assign loadSkid        = accept & (~outFree | skidValid);

  assign errHit  = consume & ~drop & outData[USER_WIDTH + 1];
  assign dropHit = consume & drop;

  // Occupancy flags of the two storage slots. All in-flight beats are lost on reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      outValid  <= 1'b0;
      skidValid <= 1'b0;
    end else begin
      if (outFree) begin
        outValid <= skidValid | accept;
      end
      if (loadOutFromSkid) begin
        skidValid <= loadSkid;
      end else if (loadSkid) begin
        skidValid <= 1'b1;
      end
    end
  end

  // Payload registers. These carry no reset because the valid flags qualify them.
  always_ff @(posedge CLK) begin
    if (loadOutFromSkid) begin
      outData <= skidData;
    end else if (loadOutFromData) begin
      outData <= DATA;
    end
    if (loadSkid) begin
      skidData <= DATA;
    end
  end

  // Saturating statistics counters. A beat is either delivered or dropped, never both.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      errCnt  <= '0;
      dropCnt <= '0;
    end else begin
      if (errHit && (errCnt != '1)) begin
        errCnt <= errCnt + CNT_WIDTH'(1);
      end
      if (dropHit && (dropCnt != '1)) begin
        dropCnt <= dropCnt + CNT_WIDTH'(1);
      end
    end
  end

  // One-hot valid toward the masters, decoded only from registered state.
  always_comb begin
    BVALID = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      BVALID[i] = outValid & ~drop & (sel == SEL_WIDTH'(i));
    end
  end

  assign BID      = outData[DATA_W-1 -: ID_WIDTH];
  assign BRESP    = outData[USER_WIDTH +: 2];
  assign BUSER    = outData[USER_WIDTH-1:0];
  assign ERR_CNT  = errCnt;
  assign DROP_CNT = dropCnt;

endmodule

// File: tb/tb_wb_backward_router.sv
// tb_wb_backward_router
// Bench for wb_backward_router. It drives three instances:
//   - a default instance, checked through a scoreboard,
//   - an instance with 2-bit counters, used for the saturation case,
//   - a three-master instance, used for the drop path.
module tb_wb_backward_router;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] data = '0;

  logic        valid0 = 1'b0;
  logic        ready0;
  logic [7:0]  bid0;
  logic [1:0]  bresp0;
  logic [3:0]  buser0;
  logic [3:0]  bvalid0;
  logic [3:0]  bready0 = 4'h0;
  logic [15:0] err0;
  logic [15:0] drop0;

  logic        valid1 = 1'b0;
  logic        ready1;
  logic [7:0]  bid1;
  logic [1:0]  bresp1;
  logic [3:0]  buser1;
  logic [3:0]  bvalid1;
  logic [3:0]  bready1 = 4'h0;
  logic [1:0]  err1;
  logic [1:0]  drop1;

  logic        valid2 = 1'b0;
  logic        ready2;
  logic [7:0]  bid2;
  logic [1:0]  bresp2;
  logic [3:0]  buser2;
  logic [2:0]  bvalid2;
  logic [2:0]  bready2 = 3'h0;
  logic [15:0] err2;
  logic [15:0] drop2;

  int compared = 0;
  int mismatched = 0;
  logic [13:0] sbq[$];

  typedef struct {
    logic [13:0] data;
    logic [3:0]  expBvalid;
    logic [15:0] expErr;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  wb_backward_router dut (
    .CLK(clk), .RESET(reset), .DATA(data), .VALID(valid0), .READY(ready0),
    .BID(bid0), .BRESP(bresp0), .BUSER(buser0), .BVALID(bvalid0), .BREADY(bready0),
    .ERR_CNT(err0), .DROP_CNT(drop0)
  );

  wb_backward_router #(.CNT_WIDTH(2)) dutSat (
    .CLK(clk), .RESET(reset), .DATA(data), .VALID(valid1), .READY(ready1),
    .BID(bid1), .BRESP(bresp1), .BUSER(buser1), .BVALID(bvalid1), .BREADY(bready1),
    .ERR_CNT(err1), .DROP_CNT(drop1)
  );

  wb_backward_router #(.NUM_MASTERS(3)) dut3 (
    .CLK(clk), .RESET(reset), .DATA(data), .VALID(valid2), .READY(ready2),
    .BID(bid2), .BRESP(bresp2), .BUSER(buser2), .BVALID(bvalid2), .BREADY(bready2),
    .ERR_CNT(err2), .DROP_CNT(drop2)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [13:0] d, input logic v);
    data   = d;
    valid0 = v;
    tick();
  endtask

  // Record every beat the default instance accepts, in order.
  always @(posedge clk) begin
    if (!reset && valid0 && ready0) begin
      sbq.push_back(data);
    end
  end

  // Compare each offered beat with the oldest accepted one, and retire it on handshake.
  always @(negedge clk) begin
    logic [13:0] exp;
    logic [3:0]  oh;
    if (!reset && (bvalid0 != 4'h0)) begin
      if (sbq.size() == 0) begin
        checkOutput("sb_unexpected_beat", {28'h0, bvalid0}, 32'h0);
      end else begin
        exp = sbq[0];
        oh  = 4'b0001 << exp[13:12];
        checkOutput("sb_bvalid", {28'h0, bvalid0}, {28'h0, oh});
        checkOutput("sb_bid",    {24'h0, bid0},    {24'h0, exp[13:6]});
        checkOutput("sb_bresp",  {30'h0, bresp0},  {30'h0, exp[5:4]});
        checkOutput("sb_buser",  {28'h0, buser0},  {28'h0, exp[3:0]});
        if ((bvalid0 & bready0) != 4'h0) begin
          void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    vecs[0] = '{{8'h41, 2'b00, 4'h5}, 4'b0010, 16'd0};
    vecs[1] = '{{8'h02, 2'b10, 4'h1}, 4'b0001, 16'd1};
    vecs[2] = '{{8'hC3, 2'b11, 4'hF}, 4'b1000, 16'd2};
    vecs[3] = '{{8'h85, 2'b01, 4'h3}, 4'b0100, 16'd2};
    vecs[4] = '{{8'h7F, 2'b00, 4'h0}, 4'b0010, 16'd2};
    vecs[5] = '{{8'hBE, 2'b10, 4'hA}, 4'b0100, 16'd3};

    // Reset held for two cycles while VALID is high.
    reset = 1'b1;
    valid0 = 1'b1;
    data = {8'h11, 2'b10, 4'h2};
    bready0 = 4'hF;
    tick();
    tick();
    @(negedge clk);
    checkOutput("rst_ready",  {31'h0, ready0}, 32'h0);
    checkOutput("rst_bvalid", {28'h0, bvalid0}, 32'h0);
    checkOutput("rst_err",    {16'h0, err0}, 32'h0);
    checkOutput("rst_drop",   {16'h0, drop0}, 32'h0);
    tick();
    reset = 1'b0;
    valid0 = 1'b0;
    sbq.delete();
    @(negedge clk);
    checkOutput("rel_ready",  {31'h0, ready0}, 32'h1);
    checkOutput("rel_bvalid", {28'h0, bvalid0}, 32'h0);
    tick();

    // Table of single beats. Each row is delivered for one cycle and may bump ERR_CNT.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].data, 1'b1);
      valid0 = 1'b0;
      @(negedge clk);
      checkOutput($sformatf("vec%0d_bvalid", i), {28'h0, bvalid0}, {28'h0, vecs[i].expBvalid});
      checkOutput($sformatf("vec%0d_bid", i), {24'h0, bid0}, {24'h0, vecs[i].data[13:6]});
      tick();
      @(negedge clk);
      checkOutput($sformatf("vec%0d_gone", i), {28'h0, bvalid0}, 32'h0);
      checkOutput($sformatf("vec%0d_err", i), {16'h0, err0}, {16'h0, vecs[i].expErr});
    end

    // Backpressure. Master 0 is stalled, and ready on the other ports must be ignored.
    bready0 = 4'hE;
    applyStimulus({8'h01, 2'b00, 4'h1}, 1'b1);
    data = {8'h02, 2'b00, 4'h2};
    @(negedge clk);
    checkOutput("bp_ready_a", {31'h0, ready0}, 32'h1);
    checkOutput("bp_bvalid_a", {28'h0, bvalid0}, 32'h1);
    tick();
    data = {8'h03, 2'b00, 4'h3};
    @(negedge clk);
    checkOutput("bp_ready_full", {31'h0, ready0}, 32'h0);
    tick();
    @(negedge clk);
    checkOutput("bp_hold_ready", {31'h0, ready0}, 32'h0);
    checkOutput("bp_hold_bid", {24'h0, bid0}, 32'h01);
    checkOutput("bp_accepted", sbq.size(), 32'd2);
    bready0 = 4'h1;
    tick();
    @(negedge clk);
    checkOutput("bp_second", {24'h0, bid0}, 32'h02);
    tick();
    valid0 = 1'b0;
    @(negedge clk);
    checkOutput("bp_third", {24'h0, bid0}, 32'h03);
    tick();
    @(negedge clk);
    checkOutput("bp_drained", {28'h0, bvalid0}, 32'h0);
    checkOutput("bp_sb_empty", sbq.size(), 32'd0);

    // Streaming. Sixteen beats with the master rotating and every port ready.
    bready0 = 4'hF;
    for (int i = 0; i < 16; i++) begin
      logic [1:0] m;
      logic [3:0] lo;
      m  = i[1:0];
      lo = i[3:0];
      applyStimulus({m, 2'b00, lo, 2'b00, lo}, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("st%0d_ready", i), {31'h0, ready0}, 32'h1);
      checkOutput($sformatf("st%0d_bvalid", i), {28'h0, bvalid0}, {28'h0, 4'b0001 << m});
    end
    valid0 = 1'b0;
    tick();
    @(negedge clk);
    checkOutput("st_done", {28'h0, bvalid0}, 32'h0);

    // Reset in the middle of traffic, with both slots full and ERR_CNT nonzero.
    checkOutput("mid_err_before", {16'h0, err0}, 32'd3);
    bready0 = 4'h0;
    applyStimulus({8'h44, 2'b11, 4'h4}, 1'b1);
    applyStimulus({8'h45, 2'b11, 4'h5}, 1'b1);
    valid0 = 1'b0;
    reset = 1'b1;
    tick();
    @(negedge clk);
    checkOutput("mid_rst_bvalid", {28'h0, bvalid0}, 32'h0);
    checkOutput("mid_rst_ready", {31'h0, ready0}, 32'h0);
    checkOutput("mid_rst_err", {16'h0, err0}, 32'h0);
    tick();
    reset = 1'b0;
    sbq.delete();
    bready0 = 4'hF;
    @(negedge clk);
    checkOutput("mid_rel_ready", {31'h0, ready0}, 32'h1);
    checkOutput("mid_rel_bvalid", {28'h0, bvalid0}, 32'h0);
    tick();

    // Saturation of a 2-bit ERR_CNT after five error beats.
    bready1 = 4'hF;
    valid1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      logic [7:0] id;
      id = 8'h40 + 8'(i);
      data = {id, 2'b10, 4'h0};
      tick();
    end
    valid1 = 1'b0;
    tick();
    tick();
    @(negedge clk);
    checkOutput("sat_err", {30'h0, err1}, 32'd3);
    checkOutput("sat_drop", {30'h0, drop1}, 32'd0);

    // Drop path on the three-master instance. Select value 3 has no port.
    bready2 = 3'b111;
    valid2 = 1'b1;
    data = {8'hC0, 2'b10, 4'h0};
    tick();
    data = {8'h80, 2'b00, 4'h7};
    @(negedge clk);
    checkOutput("drop_bvalid", {29'h0, bvalid2}, 32'h0);
    checkOutput("drop_ready", {31'h0, ready2}, 32'h1);
    tick();
    valid2 = 1'b0;
    @(negedge clk);
    checkOutput("drop_cnt", {16'h0, drop2}, 32'd1);
    checkOutput("drop_err", {16'h0, err2}, 32'd0);
    checkOutput("drop_next_bvalid", {29'h0, bvalid2}, 32'b100);
    checkOutput("drop_next_bid", {24'h0, bid2}, 32'h80);
    checkOutput("drop_next_ready", {31'h0, ready2}, 32'h1);
    tick();
    @(negedge clk);
    checkOutput("drop_idle", {29'h0, bvalid2}, 32'h0);

    checkOutput("sb_final_empty", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
